vram_arbiter: RTL and testbench
===============================

Name: vram_arbiter

Overview:
- Shares one single-port pixel RAM between two requesters: the VGA scan-out fetch (reader) and the UART command path (writer) that loads pixels.
- The reader has absolute priority because a late pixel corrupts the display. The writer uses free cycles, optionally only during blanking.
- Sits between the VGA timing/pixel pipeline and the RAM inside the top level. It runs on the 50 MHz system clock; the pixel clock is 25 MHz, so at most every other cycle is a read.

Parameters:
- ADDR_W, 16, pixel address width.
- DATA_W, 15, pixel width (5:5:5 RGB).
- MEM_LAT, 1, RAM read latency in cycles from mem_en to valid mem_rdata (legal 1..3).
- STARVE_LIM, 1024, consecutive write-wait cycles that set the starvation flag.

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous active-low reset
- rd_req  in  1  single-cycle read request from scan-out; not held
- rd_addr  in  ADDR_W  read address, valid with rd_req
- rd_valid  out  1  read data valid strobe
- rd_data  out  DATA_W  read data
- wr_req  in  1  write request; held until wr_ack
- wr_addr  in  ADDR_W  write address, stable while wr_req
- wr_data  in  DATA_W  write data, stable while wr_req
- wr_ack  out  1  one-cycle pulse when the write is issued to RAM
- blank  in  1  1 during h/v blanking (from VGA timing)
- wr_blank_only  in  1  config: 1 = writes granted only while blank=1
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data
- wr_starved  out  1  sticky starvation flag
- starve_clr  in  1  clears wr_starved

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, wait counter 0, read pipeline flushed.
- The FSM has 3 states, IDLE/READ/WRITE, and each state names what is on the memory port this cycle. All memory outputs are registered. Decisions are made from inputs sampled at edge N, and the result is driven during cycle N+1.
- Priority rule at each edge:
  - rd_req=1 -> READ with rd_addr.
  - Else, wr_req=1 and not already acked and (wr_blank_only=0 or blank=1) -> WRITE.
  - Else -> IDLE.
- READ: mem_en=1, mem_we=0, mem_addr=captured rd_addr.
  - A MEM_LAT-deep valid shift register is used.
  - rd_valid=1 and rd_data=mem_rdata exactly MEM_LAT+1 cycles after the rd_req edge.
  - rd_data holds its last value when rd_valid=0.
- WRITE: mem_en=1, mem_we=1, mem_addr/mem_wdata=wr_addr/wr_data.
  - wr_ack=1 in the same cycle.
  - The writer drops or changes its request on the edge after ack. The arbiter never issues two writes for one request: an ack_pending bit masks wr_req for the cycle immediately after wr_ack.
- IDLE: mem_en=0, mem_we=0, mem_addr/mem_wdata hold.
- Simultaneous rd_req and wr_req: the read wins and the write waits with no ack.
- Back-to-back rd_req on every cycle is supported; the writer then waits indefinitely.
- Starvation:
  - The wait counter increments each cycle wr_req=1 and the write is not granted. It saturates at STARVE_LIM and clears on wr_ack or when wr_req=0.
  - wr_starved sets when the counter reaches STARVE_LIM.
  - starve_clr clears wr_starved and the counter; set wins if both occur in the same cycle.
- wr_blank_only changing mid-wait takes effect at the next decision edge.
- Reset asserted mid-operation: outputs go to 0 immediately (async). Any in-flight read data is discarded; no rd_valid is produced after reset is released for pre-reset requests.

Decomposition:
- Shared VGA package holds:
  - the state enum (IDLE/READ/WRITE);
  - the default ADDR_W and DATA_W;
  - the 5:5:5 pixel typedef also used by the colour output stage.
- One natural sub-module: vram_rd_pipe, the MEM_LAT-deep valid/data alignment shift register.

Test Plan:
- Single read: rd_req at edge 10 with addr 0x0040 and RAM holding 0x7C00 there, MEM_LAT=1 -> mem_en=1 and mem_we=0 in cycle 11; rd_valid=1 and rd_data=0x7C00 in cycle 12 only.
- Single write: wr_req held with addr 0x1234 and data 0x03E0, blank=1 -> exactly one cycle with mem_we=1, addr 0x1234, data 0x03E0 and wr_ack=1; a later read of 0x1234 returns 0x03E0.
- Collision: rd_req and wr_req on the same edge, then rd_req every other cycle -> read issued first, write issued in the next free cycle; exactly one wr_ack.
- Blank gating: wr_blank_only=1, blank=0 for 200 cycles then 1 -> no mem_we during the 200 cycles; wr_ack within 2 cycles of blank rising.
- Starvation: STARVE_LIM=16, rd_req every cycle with wr_req held -> wr_starved=1 after 16 wait cycles; a starve_clr pulse clears it, and it re-sets after 16 more cycles.
- Reset mid-read: rd_req issued, rst_n low in the following cycle -> all outputs 0 at once; no rd_valid after reset is released.

Source files
------------

// File: rtl/vram_arbiter_pkg.sv
// vram_arbiter_pkg: frame-buffer types and defaults shared by the
// VRAM arbiter, its read pipe and the colour output stage.
package vram_arbiter_pkg;

  localparam int unsigned VRAM_ADDR_W = 16;
  localparam int unsigned VRAM_DATA_W = 15;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

  typedef enum logic [1:0] {
    ARB_IDLE  = ST_IDLE,
    ARB_READ  = ST_READ,
    ARB_WRITE = ST_WRITE
  } arb_state_e;

  typedef struct packed {
    logic [4:0] r;
    logic [4:0] g;
    logic [4:0] b;
  } pixel_t;

  function automatic pixel_t pix_unpack(
    input logic [VRAM_DATA_W-1:0] w
  );
    return pixel_t'(w);
  endfunction

endpackage

// File: rtl/vram_rd_pipe.sv
// vram_rd_pipe: lines read-valid up with the RAM output latency
// and holds the last returned pixel between reads.
module vram_rd_pipe
  import vram_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W  = VRAM_DATA_W,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              issue_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic [MEM_LAT-1:0] vld_q, vld_d;
  logic [DATA_W-1:0]  data_q, data_d;

  always_comb begin
    vld_d    = vld_q << 1;
    vld_d[0] = issue_i;
  end

  assign valid_o = vld_q[MEM_LAT-1];

  // RAM data is passed straight through on the valid cycle
  assign data_d = valid_o ? mem_rdata_i : data_q;
  assign data_o = data_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q  <= '0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the single-port pixel RAM between scan-out
// reads (absolute priority) and UART pixel writes.
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = VRAM_ADDR_W,
  parameter int unsigned DATA_W     = VRAM_DATA_W,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_LIM = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              blank,
  input  logic              wr_blank_only,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wr_starved,
  input  logic              starve_clr
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIM + 1);
  localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIM);

  logic [1:0]        state_q, state_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              wr_ack_q, wr_ack_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_raw;
  logic              starved_q, starved_d;
  logic              wr_ok, reach;

  // wr_ack_q doubles as ack_pending: the writer still
  // shows the old request on the edge after its ack
  assign wr_ok = !rd_req && wr_req && !wr_ack_q
              && (!wr_blank_only || blank);

  always_comb begin
    state_d = ST_IDLE;
    unique case (1'b1)
      rd_req:  state_d = ST_READ;
      wr_ok:   state_d = ST_WRITE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_en_d    = (state_d != ST_IDLE);
    mem_we_d    = (state_d == ST_WRITE);
    wr_ack_d    = (state_d == ST_WRITE);
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (state_d == ST_READ) begin
      mem_addr_d = rd_addr;
    end else if (state_d == ST_WRITE) begin
      mem_addr_d  = wr_addr;
      mem_wdata_d = wr_data;
    end
  end

  // set only on the edge the count first reaches the limit,
  // so a clear while saturated sticks
  always_comb begin
    cnt_raw = cnt_q;
    if (!wr_req || wr_ack_q) begin
      cnt_raw = '0;
    end else if (!wr_ok && cnt_q != LIM) begin
      cnt_raw = cnt_q + CNT_W'(1);
    end
    reach = (cnt_raw == LIM) && (cnt_q != LIM);
    cnt_d = starve_clr ? '0 : cnt_raw;
    starved_d = starved_q;
    if (reach) begin
      starved_d = 1'b1;
    end else if (starve_clr) begin
      starved_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wr_ack_q    <= 1'b0;
      cnt_q       <= '0;
      starved_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wr_ack_q    <= wr_ack_d;
      cnt_q       <= cnt_d;
      starved_q   <= starved_d;
    end
  end

  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign wr_ack     = wr_ack_q;
  assign wr_starved = starved_q;

  vram_rd_pipe #(
    .DATA_W  (DATA_W),
    .MEM_LAT (MEM_LAT)
  ) u_rd_pipe (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .issue_i     (state_q == ST_READ),
    .mem_rdata_i (mem_rdata),
    .valid_o     (rd_valid),
    .data_o      (rd_data)
  );

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: vectors, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_vram_arbiter;

  localparam int LIM = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_req;
  logic [15:0] rd_addr;
  logic        rd_valid;
  logic [14:0] rd_data;
  logic        wr_req;
  logic [15:0] wr_addr;
  logic [14:0] wr_data;
  logic        wr_ack;
  logic        blank;
  logic        wr_blank_only;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [14:0] mem_wdata;
  logic [14:0] mem_rdata = '0;
  logic        wr_starved;
  logic        starve_clr;

  bit [14:0] ram [0:65535];
  bit [14:0] model_mem [0:65535];

  int checks = 0;
  int failures = 0;

  vram_arbiter #(
    .ADDR_W     (16),
    .DATA_W     (15),
    .MEM_LAT    (1),
    .STARVE_LIM (LIM)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rd_req        (rd_req),
    .rd_addr       (rd_addr),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .wr_req        (wr_req),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_ack        (wr_ack),
    .blank         (blank),
    .wr_blank_only (wr_blank_only),
    .mem_en        (mem_en),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .wr_starved    (wr_starved),
    .starve_clr    (starve_clr)
  );

  always #10 clk = ~clk;

  // single-port RAM, one cycle read latency
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // writer holds its request through the edge after ack
  task automatic write_txn(input logic [15:0] a,
                           input logic [14:0] d,
                           input string nm);
    int  acks;
    bit  drop;
    acks = 0;
    drop = 0;
    blank = 1'b1;
    wr_blank_only = 1'b0;
    wr_addr = a;
    wr_data = d;
    wr_req = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (drop) wr_req = 1'b0;
      drop = 0;
      if (wr_ack) begin
        acks++;
        drop = 1;
        chk({nm, "_we"}, mem_we, 1'b1);
        chk({nm, "_addr"}, mem_addr, a);
        chk({nm, "_wdata"}, mem_wdata, d);
      end
    end
    wr_req = 1'b0;
    chk({nm, "_acks"}, acks, 1);
  endtask

  task automatic read_txn(input logic [15:0] a,
                          input logic [14:0] d,
                          input string nm);
    rd_addr = a;
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    chk({nm, "_en"}, mem_en, 1'b1);
    chk({nm, "_we"}, mem_we, 1'b0);
    chk({nm, "_addr"}, mem_addr, a);
    chk({nm, "_early_valid"}, rd_valid, 1'b0);
    @(negedge clk);
    chk({nm, "_valid"}, rd_valid, 1'b1);
    chk({nm, "_data"}, rd_data, d);
    @(negedge clk);
    chk({nm, "_valid_off"}, rd_valid, 1'b0);
    chk({nm, "_hold"}, rd_data, d);
  endtask

  typedef struct {
    logic rd;
    logic wr;
    logic blk;
    logic bo;
    logic en;
    logic we;
    logic ack;
  } vec_t;

  typedef struct {
    int          due;
    logic [14:0] d;
  } rd_t;

  vec_t vecs [8];
  rd_t  rq [$];

  int   acks, first_ack, we_seen, delay, rv_seen;
  int   wn, old;
  bit   drop, rv, g_wr, hit;
  logic e_en, e_we, e_ack, e_st;
  logic [15:0] e_addr;
  logic [14:0] e_wd, e_rd;

  initial begin
    rst_n = 1'b0;
    rd_req = 0; rd_addr = '0;
    wr_req = 0; wr_addr = '0; wr_data = '0;
    blank = 0; wr_blank_only = 0; starve_clr = 0;

    //            rd wr blk bo en we ack
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_en", mem_en, 1'b0);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_addr", mem_addr, 16'h0);
    chk("rst_wdata", mem_wdata, 15'h0);
    chk("rst_ack", wr_ack, 1'b0);
    chk("rst_valid", rd_valid, 1'b0);
    chk("rst_rdata", rd_data, 15'h0);
    chk("rst_starved", wr_starved, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      rd_req = vecs[i].rd;
      wr_req = vecs[i].wr;
      blank = vecs[i].blk;
      wr_blank_only = vecs[i].bo;
      rd_addr = 16'h0100 + 16'(i);
      wr_addr = 16'h0200 + 16'(i);
      wr_data = 15'(i + 1);
      @(negedge clk);
      chk($sformatf("vec%0d_en", i), mem_en, vecs[i].en);
      chk($sformatf("vec%0d_we", i), mem_we, vecs[i].we);
      chk($sformatf("vec%0d_ack", i), wr_ack, vecs[i].ack);
      if (vecs[i].en)
        chk($sformatf("vec%0d_addr", i), mem_addr,
            vecs[i].rd ? rd_addr : wr_addr);
      rd_req = 0; wr_req = 0; blank = 0; wr_blank_only = 0;
      repeat (3) @(negedge clk);
    end

    write_txn(16'h0040, 15'h7C00, "wr_pre");
    read_txn(16'h0040, 15'h7C00, "rd_single");
    write_txn(16'h1234, 15'h03E0, "wr_single");
    read_txn(16'h1234, 15'h03E0, "rd_back");

    // collision, then reads on every other cycle
    blank = 1; wr_blank_only = 0;
    wr_addr = 16'h0050; wr_data = 15'h001F; wr_req = 1;
    rd_addr = 16'h0040;
    acks = 0; drop = 0; first_ack = -1;
    for (int k = 0; k < 10; k++) begin
      rd_req = (k % 2 == 0) && (k < 8);
      @(negedge clk);
      if (k == 0) begin
        chk("col_rd_en", mem_en, 1'b1);
        chk("col_rd_we", mem_we, 1'b0);
      end
      if (k == 1) begin
        chk("col_rd_valid", rd_valid, 1'b1);
        chk("col_rd_data", rd_data, 15'h7C00);
      end
      if (drop) wr_req = 0;
      drop = 0;
      if (wr_ack) begin
        acks++;
        if (first_ack < 0) first_ack = k;
        drop = 1;
      end
    end
    wr_req = 0; rd_req = 0;
    chk("col_acks", acks, 1);
    chk("col_ack_slot", first_ack, 1);
    read_txn(16'h0050, 15'h001F, "col_back");

    // blank gating
    wr_blank_only = 1; blank = 0;
    wr_addr = 16'h0060; wr_data = 15'h1111; wr_req = 1;
    we_seen = 0;
    repeat (200) begin
      @(negedge clk);
      if (mem_we) we_seen++;
    end
    chk("blank_no_we", we_seen, 0);
    chk("blank_starved", wr_starved, 1'b1);
    blank = 1;
    delay = -1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (wr_ack && delay < 0) begin
        delay = k;
        wr_req = 0;
      end
    end
    wr_req = 0;
    chk("blank_ack_in_2", (delay >= 1 && delay <= 2), 1);
    wr_blank_only = 0;
    starve_clr = 1;
    @(negedge clk);
    starve_clr = 0;
    chk("blank_starve_clr", wr_starved, 1'b0);

    // starvation under continuous reads
    blank = 0;
    rd_req = 1; rd_addr = 16'h0040;
    wr_addr = 16'h0070; wr_data = 15'h2222; wr_req = 1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 15) chk("starve_15", wr_starved, 1'b0);
      if (k == 16) chk("starve_16", wr_starved, 1'b1);
    end
    starve_clr = 1;
    @(negedge clk);
    starve_clr = 0;
    chk("starve_cleared", wr_starved, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 15) chk("starve_re_15", wr_starved, 1'b0);
      if (k == 16) chk("starve_re_16", wr_starved, 1'b1);
    end
    rd_req = 0; wr_req = 0;
    starve_clr = 1;
    @(negedge clk);
    starve_clr = 0;
    @(negedge clk);

    // reset during a read
    rd_addr = 16'h0040;
    rd_req = 1;
    @(posedge clk);
    #2;
    rd_req = 0;
    chk("rstmid_en_before", mem_en, 1'b1);
    rst_n = 0;
    #1;
    chk("rstmid_en", mem_en, 1'b0);
    chk("rstmid_addr", mem_addr, 16'h0);
    chk("rstmid_valid", rd_valid, 1'b0);
    chk("rstmid_rdata", rd_data, 15'h0);
    chk("rstmid_ack", wr_ack, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    rv_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (rd_valid) rv_seen++;
    end
    chk("rstmid_no_valid", rv_seen, 0);

    // randomized traffic against the reference model
    e_en = 0; e_we = 0; e_ack = 0; e_st = 0;
    e_addr = '0; e_wd = '0; e_rd = '0;
    wn = 0; drop = 0;
    blank = 0; wr_blank_only = 0;
    for (int o = 0; o < 3000; o++) begin
      rv = 0;
      if (rq.size() > 0 && rq[0].due == o) begin
        rv = 1;
        e_rd = rq[0].d;
        void'(rq.pop_front());
      end
      chk("rnd_valid", rd_valid, rv);
      chk("rnd_rdata", rd_data, e_rd);
      chk("rnd_en", mem_en, e_en);
      chk("rnd_we", mem_we, e_we);
      chk("rnd_ack", wr_ack, e_ack);
      chk("rnd_starved", wr_starved, e_st);
      if (e_en) chk("rnd_addr", mem_addr, e_addr);
      if (e_we) chk("rnd_wdata", mem_wdata, e_wd);

      if (drop) begin
        wr_req = 0;
        drop = 0;
      end
      if (wr_ack) drop = 1;
      if (!wr_req && !drop && $urandom_range(3) == 0) begin
        wr_req = 1;
        wr_addr = 16'h0100 + 16'($urandom_range(63));
        wr_data = 15'($urandom);
      end
      rd_req = ($urandom_range(2) == 0);
      rd_addr = 16'h0100 + 16'($urandom_range(63));
      if ($urandom_range(7) == 0) blank = ~blank;
      if ($urandom_range(31) == 0) wr_blank_only = ~wr_blank_only;
      starve_clr = ($urandom_range(39) == 0);

      g_wr = !rd_req && wr_req && !e_ack
          && (!wr_blank_only || blank);
      old = wn;
      if (!wr_req || e_ack) wn = 0;
      else if (!g_wr && wn < LIM) wn++;
      hit = (wn == LIM) && (old != LIM);
      if (starve_clr) wn = 0;
      if (hit) e_st = 1;
      else if (starve_clr) e_st = 0;
      if (rd_req) begin
        rq.push_back('{o + 2, model_mem[rd_addr]});
        e_addr = rd_addr;
      end else if (g_wr) begin
        model_mem[wr_addr] = wr_data;
        e_addr = wr_addr;
        e_wd = wr_data;
      end
      e_en = rd_req || g_wr;
      e_we = g_wr;
      e_ack = g_wr;
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
